dds_stream_out: RTL

Sample timer and AXI-Stream output stage for the DDS. It generates the periodic sample strobe that closes each DDS accumulation window and captures the registered DDS output one cycle later. Captured samples are buffered in a small FIFO and presented on an AXI-Stream master port, with `tlast` framing every programmed number of samples.

---
 rtl/dds_pkg.sv | 29 ++
 rtl/sample_fifo.sv | 84 ++++++++
 rtl/dds_stream_out.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared constants and types for the DDS output path.
//   DDS_SIG_WIDTH  default sample width
//   DDS_RST_BIT    control register bit: soft reset (level)
//   DDS_STRT_BIT   control register bit: start (level)
//   DDS_MIN_DIV    smallest usable sample period in clk cycles
//   dds_sample_t   FIFO entry layout: {last, data}
//   eff_div()      clamps a programmed divider to DDS_MIN_DIV
// -----------------------------------------------------------------------------
package dds_pkg;

    localparam int          DDS_SIG_WIDTH = 16;
    localparam int          DDS_RST_BIT   = 0;
    localparam int          DDS_STRT_BIT  = 1;
    localparam logic [31:0] DDS_MIN_DIV   = 32'd2;

    typedef struct packed {
        logic                     last;
        logic [DDS_SIG_WIDTH-1:0] data;
    } dds_sample_t;

    // Values below 2 cannot give the DDS a full accumulation window between
    // strobes, so they are silently raised to the minimum.
    function automatic logic [31:0] eff_div(input logic [31:0] div);
        return (div < DDS_MIN_DIV) ? DDS_MIN_DIV : div;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Synchronous show-ahead FIFO holding {last, data} sample entries.
// The head entry is always visible on rd_data; rd_en pops it when not empty.
// A write into a full FIFO is accepted only if a pop happens in the same
// cycle; wr_ack reports whether the write was taken. clr empties the FIFO
// synchronously and overrides any write or read in that cycle.
// DEPTH must be a power of two (pointers wrap naturally) and at least 4.
//
// Ports:
//   clk, a_rst_n      clock, async active-low reset
//   clr               synchronous clear
//   wr_en, wr_data    write request and entry
//   wr_ack            write accepted this cycle
//   rd_en             pop request
//   rd_data           head entry (undefined while empty)
//   full, empty       occupancy flags
//   level             registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sample_fifo
    import dds_pkg::*;
#(
    parameter int WIDTH = $bits(dds_sample_t),
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             a_rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign rd_ok   = rd_en && !empty && !clr;
    assign wr_ack  = wr_en && (!full || rd_ok) && !clr;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ack) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_ack && !rd_ok) begin
                level <= level + LVL_W'(1);
            end else if (rd_ok && !wr_ack) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Storage is not reset; entries are only visible once written.
    always_ff @(posedge clk) begin
        if (wr_ack) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/dds_stream_out.sv
// -----------------------------------------------------------------------------
// dds_stream_out
// Sample timer and AXI-Stream output stage for the DDS. A period counter
// issues a one-cycle o_sample_en every div_eff clk cycles; one cycle later
// (cap_en) the registered DDS output is pushed into a sample FIFO together
// with its packet-framing tlast bit. The FIFO head drives an AXI-Stream
// master port.
//
// Ports:
//   clk, a_rst_n      clock, async active-low reset
//   i_ctrl_reg        bit0 soft reset, bit1 start (levels)
//   i_clk_div_reg     sample period in clk cycles (values <2 act as 2)
//   i_pkt_len_reg     samples per packet, 0 = no tlast
//   o_sample_en       one-cycle strobe to the DDS
//   i_dds_signal      DDS output, valid the cycle after o_sample_en
//   m_axis_*          AXI-Stream master (tdata, tvalid, tready, tlast)
//   o_overflow        sticky: a sample was dropped on a full FIFO
//   o_fifo_level      FIFO occupancy
// -----------------------------------------------------------------------------
module dds_stream_out
    import dds_pkg::*;
#(
    parameter int SIG_WIDTH  = DDS_SIG_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 a_rst_n,
    input  logic [31:0]          i_ctrl_reg,
    input  logic [31:0]          i_clk_div_reg,
    input  logic [15:0]          i_pkt_len_reg,
    output logic                 o_sample_en,
    input  logic [SIG_WIDTH-1:0] i_dds_signal,
    output logic [SIG_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 o_overflow,
    output logic [LVL_W-1:0]     o_fifo_level
);

    // FIFO entries use the dds_sample_t layout {last, data} at SIG_WIDTH.
    localparam int ENTRY_W = SIG_WIDTH + 1;

    logic               soft_rst;
    logic               start;
    logic               ctrl_unused;

    logic [31:0]        period_cnt;
    logic [31:0]        period_len;
    logic [31:0]        period_len_q;
    logic               period_end;
    logic               cap_en;

    logic [15:0]        pkt_cnt;
    logic               push_last;
    logic               pop;

    logic               wr_ack;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;

    assign soft_rst    = i_ctrl_reg[DDS_RST_BIT];
    assign start       = i_ctrl_reg[DDS_STRT_BIT];
    assign ctrl_unused = ^i_ctrl_reg[31:2];

    // The divider is captured in the first cycle of each period (counter at
    // 0) so a register write never stretches or truncates a running period.
    assign period_len = (period_cnt == '0) ? eff_div(i_clk_div_reg) : period_len_q;
    assign period_end = (period_cnt == period_len - 32'd1);

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            period_cnt   <= '0;
            period_len_q <= DDS_MIN_DIV;
            o_sample_en  <= 1'b0;
            cap_en       <= 1'b0;
        end else if (soft_rst) begin
            period_cnt   <= '0;
            period_len_q <= DDS_MIN_DIV;
            o_sample_en  <= 1'b0;
            cap_en       <= 1'b0;
        end else begin
            // A strobe already issued is captured even if start has dropped.
            cap_en <= o_sample_en;
            if (!start) begin
                period_cnt  <= '0;
                o_sample_en <= 1'b0;
            end else begin
                if (period_cnt == '0) begin
                    period_len_q <= period_len;
                end
                o_sample_en <= period_end;
                period_cnt  <= period_end ? '0 : period_cnt + 32'd1;
            end
        end
    end

    // ">=" rather than "==" so that shrinking pkt_len mid-packet closes the
    // packet on the very next sample instead of running the counter around.
    assign push_last = (i_pkt_len_reg != 16'd0) &&
                       (pkt_cnt >= i_pkt_len_reg - 16'd1);
    assign pop       = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            pkt_cnt    <= '0;
            o_overflow <= 1'b0;
        end else if (soft_rst) begin
            pkt_cnt    <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_ack) begin
                pkt_cnt <= push_last ? 16'd0 : pkt_cnt + 16'd1;
            end
            if (cap_en && fifo_full && !pop) begin
                o_overflow <= 1'b1;
            end
        end
    end

    sample_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .clr     (soft_rst),
        .wr_en   (cap_en),
        .wr_data ({push_last, i_dds_signal}),
        .wr_ack  (wr_ack),
        .rd_en   (m_axis_tready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (o_fifo_level)
    );

    // FIFO storage is not reset, so the head is masked while empty to keep
    // tdata/tlast at 0 out of reset.
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : head[SIG_WIDTH-1:0];
    assign m_axis_tlast  = !fifo_empty && head[SIG_WIDTH];

endmodule
